// File: rtl/mem_stage_if.sv
// M-register inputs and W-register outputs of the Y86-64 memory stage.
// master: the pipeline around the stage. slave: mem_stage itself.
interface mem_stage_if;
  logic [3:0]  M_stat_i;
  logic [3:0]  M_icode_i;
  logic [63:0] M_valE_i;
  logic [63:0] M_valA_i;
  logic [3:0]  M_dstE_i;
  logic [3:0]  M_dstM_i;
  logic        W_stall_i;
  logic [3:0]  m_stat_o;
  logic [63:0] m_valM_o;
  logic [3:0]  W_stat_o;
  logic [3:0]  W_icode_o;
  logic [63:0] W_valE_o;
  logic [63:0] W_valM_o;
  logic [3:0]  W_dstE_o;
  logic [3:0]  W_dstM_o;

  modport master (
    output M_stat_i, M_icode_i, M_valE_i, M_valA_i, M_dstE_i, M_dstM_i, W_stall_i,
    input  m_stat_o, m_valM_o, W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o
  );

  modport slave (
    input  M_stat_i, M_icode_i, M_valE_i, M_valA_i, M_dstE_i, M_dstM_i, W_stall_i,
    output m_stat_o, m_valM_o, W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o
  );
endinterface

// File: rtl/mem_stage.sv
// Y86-64 memory-access stage with the W pipeline register.
// 8-byte little-endian data memory, combinational read, write on the clock edge.
// Optional feature macro: MEM_ALIGN_CHECK_EN (unaligned accesses raise SADR).
module mem_stage #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic        clk_i,
  input logic        rstn_i,
  mem_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK  = 4'h1;
  localparam logic [3:0] SADR  = 4'h3;
  localparam logic [3:0] RNONE = 4'hF;

  // Highest legal start address of an 8-byte access.
  localparam logic [63:0] MaxAddr = 64'(MEM_BYTES - 8);

  logic [7:0]    mem [MEM_BYTES];

  logic          mem_read;
  logic          mem_write;
  logic [63:0]   mem_addr;
  logic          misalign;
  logic          dmem_error;
  logic          wr_commit;
  logic [AW-1:0] base_idx;
  logic [63:0]   rdata;

  logic [3:0]    w_stat_q,  w_stat_d;
  logic [3:0]    w_icode_q, w_icode_d;
  logic [63:0]   w_vale_q,  w_vale_d;
  logic [63:0]   w_valm_q,  w_valm_d;
  logic [3:0]    w_dste_q,  w_dste_d;
  logic [3:0]    w_dstm_q,  w_dstm_d;

  // Decode access kind and address from the icode.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 64'd0;
    unique case (bus.M_icode_i)
      IRMMOVQ, IPUSHQ, ICALL: begin
        mem_write = 1'b1;
        mem_addr  = bus.M_valE_i;
      end
      IMRMOVQ: begin
        mem_read = 1'b1;
        mem_addr = bus.M_valE_i;
      end
      IPOPQ, IRET: begin
        mem_read = 1'b1;
        mem_addr = bus.M_valA_i;
      end
      default: ;
    endcase
  end

  // Range (and optionally alignment) check; wrap-around addresses fail the unsigned compare.
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    misalign = (mem_addr[2:0] != 3'd0);
`else
    misalign = 1'b0;
`endif
    dmem_error = (mem_read || mem_write) && ((mem_addr > MaxAddr) || misalign);
    base_idx   = mem_addr[AW-1:0];
    // Squash writes behind any exception, in M or already parked in W.
    wr_commit  = mem_write && !dmem_error && (bus.M_stat_i == SAOK) && (w_stat_q == SAOK);
  end

  // Combinational little-endian 8-byte read.
  always_comb begin
    rdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rdata[i*8 +: 8] = mem[base_idx + AW'(i)];
    end
  end

  // Memory-stage outputs and W next-state; a stall holds every field.
  always_comb begin
    bus.m_stat_o = dmem_error ? SADR : bus.M_stat_i;
    bus.m_valM_o = (mem_read && !dmem_error) ? rdata : 64'd0;
    w_stat_d     = w_stat_q;
    w_icode_d    = w_icode_q;
    w_vale_d     = w_vale_q;
    w_valm_d     = w_valm_q;
    w_dste_d     = w_dste_q;
    w_dstm_d     = w_dstm_q;
    if (!bus.W_stall_i) begin
      w_stat_d  = bus.m_stat_o;
      w_icode_d = bus.M_icode_i;
      w_vale_d  = bus.M_valE_i;
      w_valm_d  = bus.m_valM_o;
      w_dste_d  = bus.M_dstE_i;
      w_dstm_d  = bus.M_dstM_i;
    end
  end

  // Data memory write. The empty reset branch drops a write whose edge meets active reset;
  // contents themselves are never cleared.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
    end else if (wr_commit) begin
      for (int i = 0; i < 8; i++) begin
        mem[base_idx + AW'(i)] <= bus.M_valA_i[i*8 +: 8];
      end
    end
  end

  // W pipeline register, resets to a bubble.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_stat_q  <= SAOK;
      w_icode_q <= INOP;
      w_vale_q  <= 64'd0;
      w_valm_q  <= 64'd0;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
    end
  end

  // Drive registered W outputs.
  always_comb begin
    bus.W_stat_o  = w_stat_q;
    bus.W_icode_o = w_icode_q;
    bus.W_valE_o  = w_vale_q;
    bus.W_valM_o  = w_valm_q;
    bus.W_dstE_o  = w_dste_q;
    bus.W_dstM_o  = w_dstm_q;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage Y86-64 pipeline, with the writeback (W) pipeline register. It consumes the M-register outputs of `mem_reg` and performs the data-memory read or write. It produces `m_valM` and `m_stat` for decode forwarding and execute condition-code suppression, and registers the W-stage values consumed by `decode_wb` and `fetch`.

## Interface
Parameters:
- MEM_BYTES, 4096: data memory size in bytes; byte-addressed, little-endian.

Ports:
- clk_i  in  1  pipeline clock
- rstn_i  in  1  reset; asynchronous assert, active-low
- M_stat_i  in  4  status from M register
- M_icode_i  in  4  instruction code from M register
- M_valE_i  in  64  ALU result; address for rmmovq/mrmovq/pushq/call
- M_valA_i  in  64  store data; address for popq/ret
- M_dstE_i  in  4  E destination register
- M_dstM_i  in  4  M destination register
- W_stall_i  in  1  hold the W register
- m_stat_o  out  4  combinational memory-stage status
- m_valM_o  out  64  combinational load data
- W_stat_o  out  4  registered status
- W_icode_o  out  4  registered icode
- W_valE_o  out  64  registered valE
- W_valM_o  out  64  registered valM
- W_dstE_o  out  4  registered dstE
- W_dstM_o  out  4  registered dstM

## Operation
- Address:
  - IRMMOVQ(4), IPUSHQ(A), ICALL(8), IMRMOVQ(5): mem_addr = M_valE_i.
  - IPOPQ(B), IRET(9): mem_addr = M_valA_i.
  - All other icodes: no access.
- Read when icode ∈ {IMRMOVQ, IPOPQ, IRET}. Write when icode ∈ {IRMMOVQ, IPUSHQ, ICALL}; write data = M_valA_i.
- Access width is always 8 bytes. Read data is {mem[a+7], …, mem[a]}.
- dmem_error = access requested and (mem_addr > MEM_BYTES-8), compared as unsigned 64-bit. Wrap-around addresses such as 0xFFFF_FFFF_FFFF_FFFC are errors.
- m_stat_o = SADR(3) if dmem_error, else M_stat_i.
- m_valM_o = read data on a valid read, else 0.
- Write commit requires all of:
  - write requested;
  - not dmem_error;
  - M_stat_i == SAOK(1);
  - W_stat_o == SAOK;
  - rstn_i high.
  - When any condition fails, memory is unchanged. This is the exception squash.
- A faulting access never updates memory; an out-of-range write is dropped entirely, with no partial bytes written.
- Memory contents are not affected by reset and are undefined at power-up.
- W register:
  - On each rising edge with W_stall_i=0, loads {m_stat_o, M_icode_i, M_valE_i, m_valM_o, M_dstE_i, M_dstM_i}.
  - With W_stall_i=1, holds all fields.

## Timing
- Read is combinational: m_valM_o and m_stat_o are valid in the same cycle as the M inputs.
- Write commits on the rising edge that ends the instruction's M cycle. A read of the same address in the next cycle returns the new data.
- A read and a write never occur in the same cycle.
- Latency M→W: 1 cycle.
- Reset (asynchronous, any time including mid-write) forces these output values:
  - W_stat_o=SAOK(1), W_icode_o=INOP(1), W_valE_o=0, W_valM_o=0, W_dstE_o=RNONE(F), W_dstM_o=RNONE(F).
  - A write whose edge coincides with active reset is discarded.
- Stall and exception: once W_stat_o ≠ SAOK, the upstream control asserts W_stall_i. The faulting instruction then stays in W, and all later writes remain suppressed until reset.

## Configuration
- MEM_ALIGN_CHECK_EN:
  - Defined: an access with mem_addr[2:0] ≠ 0 also sets dmem_error. The result is SADR, no write, and m_valM_o=0.
  - Undefined: unaligned 8-byte accesses are legal and byte-assembled across words.

## Test plan
- rmmovq with M_valE=0x100, M_valA=0x1122334455667788, then mrmovq from 0x100 → m_valM_o=0x1122334455667788; next cycle W_valM_o matches, m_stat_o=1.
- pushq with M_valE=MEM_BYTES-8 → write succeeds; with M_valE=MEM_BYTES-7 → m_stat_o=3, memory unchanged, W_stat_o=3 after the edge.
- Squash: W holds SADR with W_stall_i=1 and M presents rmmovq to 0x200 → mem[0x200..0x207] unchanged; W outputs frozen.
- popq with M_valA=0x80, M_valE=0x88 → reads from 0x80, not 0x88; W_valE_o=0x88 and W_dstM_o=M_dstM_i one cycle later.
- Assert rstn_i low mid-cycle during an rmmovq → W outputs immediately show {1,1,0,0,F,F}; target bytes unchanged.
- MEM_ALIGN_CHECK_EN defined, mrmovq at 0x103 → m_stat_o=3, m_valM_o=0; undefined → m_stat_o=1 and data is bytes 0x103..0x10A.
